// File: rtl/alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter
//
// Shares one combinational 8-bit ALU core among NUM_REQ requesters. A
// round-robin arbiter picks one valid requester while idle, latches its
// operands/opcode into registers that feed the core, and one cycle later
// captures the core result (or an unsigned NZP compare of the latched
// operands) and returns it with a one-hot response strobe.
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous, active-high
//   enable      low blocks new grants; an op in flight still completes
//   req_valid   per-requester request
//   req_ready   one-hot grant (combinational), transfer on valid & ready
//   req_op      2-bit opcode per requester (00 ADD, 01 SUB, 10 MUL, 11 DIV)
//   req_cmp     per-requester compare flag, overrides req_op for the result
//   req_rs/rt   8-bit operands per requester
//   alu_rs/rt   registered operands to the ALU core
//   alu_op      registered opcode to the ALU core
//   alu_result  combinational result from the ALU core
//   resp_valid  one-hot, single-cycle result strobe
//   resp_data   result, held until the next capture
//   busy        high while an op is executing
//   op_count    completed ops, saturating at 16'hFFFF
// ---------------------------------------------------------------------------
module alu_share_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [2*NUM_REQ-1:0]   req_op,
    input  logic [NUM_REQ-1:0]     req_cmp,
    input  logic [8*NUM_REQ-1:0]   req_rs,
    input  logic [8*NUM_REQ-1:0]   req_rt,
    output logic [7:0]             alu_rs,
    output logic [7:0]             alu_rt,
    output logic [1:0]             alu_op,
    input  logic [7:0]             alu_result,
    output logic [NUM_REQ-1:0]     resp_valid,
    output logic [7:0]             resp_data,
    output logic                   busy,
    output logic [15:0]            op_count
);

    localparam int IDW = $clog2(NUM_REQ);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_EXEC = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [IDW-1:0]       last_grant_q, last_grant_d;
    logic [IDW-1:0]       grant_q, grant_d;
    logic [7:0]           alu_rs_q, alu_rs_d;
    logic [7:0]           alu_rt_q, alu_rt_d;
    logic [1:0]           alu_op_q, alu_op_d;
    logic                 cmp_q, cmp_d;
    logic [NUM_REQ-1:0]   resp_valid_q, resp_valid_d;
    logic [7:0]           resp_data_q, resp_data_d;
    logic [15:0]          op_count_q, op_count_d;

    logic [IDW-1:0]       winner;
    logic                 win_found;
    logic                 grant_fire;
    int                   scan_idx;

    // Round-robin scan: start one past the last winner and wrap, so the
    // most recently served requester has the lowest priority.
    // NOTE: every signal written in an always_comb gets a default on entry;
    // a path that leaves one unassigned would otherwise infer a latch.
    always_comb begin
        winner    = last_grant_q;
        win_found = 1'b0;
        scan_idx  = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            scan_idx = (int'(last_grant_q) + k) % NUM_REQ;
            if (!win_found && req_valid[scan_idx]) begin
                winner    = IDW'(scan_idx);
                win_found = 1'b1;
            end
        end
    end

    // Reset gates the grant so nothing is handshaken while state is unknown.
    assign grant_fire = (state_q == S_IDLE) && enable && win_found && !reset;
    assign req_ready  = grant_fire ? (NUM_REQ'(1) << winner) : '0;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        alu_rs_d     = alu_rs_q;
        alu_rt_d     = alu_rt_q;
        alu_op_d     = alu_op_q;
        cmp_d        = cmp_q;
        resp_valid_d = '0;            // strobe lasts exactly one cycle
        resp_data_d  = resp_data_q;
        op_count_d   = op_count_q;

        case (state_q)
            S_IDLE: begin
                if (grant_fire) begin
                    alu_rs_d     = req_rs[8*winner +: 8];
                    alu_rt_d     = req_rt[8*winner +: 8];
                    alu_op_d     = req_op[2*winner +: 2];
                    cmp_d        = req_cmp[winner];
                    grant_d      = winner;
                    last_grant_d = winner;
                    state_d      = S_EXEC;
                end
            end
            S_EXEC: begin
                // Compare is unsigned and uses the latched operands, not the core.
                resp_data_d  = cmp_q ? {5'b0, alu_rs_q > alu_rt_q,
                                              alu_rs_q == alu_rt_q,
                                              alu_rs_q < alu_rt_q}
                                     : alu_result;
                resp_valid_d = NUM_REQ'(1) << grant_q;
                op_count_d   = (op_count_q == 16'hFFFF) ? op_count_q
                                                        : op_count_q + 16'd1;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            last_grant_q <= IDW'(NUM_REQ - 1);
            grant_q      <= '0;
            alu_rs_q     <= '0;
            alu_rt_q     <= '0;
            alu_op_q     <= '0;
            cmp_q        <= 1'b0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
            op_count_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            alu_rs_q     <= alu_rs_d;
            alu_rt_q     <= alu_rt_d;
            alu_op_q     <= alu_op_d;
            cmp_q        <= cmp_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            op_count_q   <= op_count_d;
        end
    end

    assign alu_rs     = alu_rs_q;
    assign alu_rt     = alu_rt_q;
    assign alu_op     = alu_op_q;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign busy       = (state_q == S_EXEC);
    assign op_count   = op_count_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_share_arbiter
//
// Bench for alu_share_arbiter with NUM_REQ = 4. Contains a stand-in ALU
// core, a table of single-requester transactions, hand-written sequences
// for enable, round-robin order, reset and saturation, and a randomized
// phase scored against a cycle-indexed reference model.
// ---------------------------------------------------------------------------
module tb_alu_share_arbiter;

    localparam int N = 4;

    logic             clk;
    logic             reset;
    logic             enable;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [2*N-1:0]   req_op;
    logic [N-1:0]     req_cmp;
    logic [8*N-1:0]   req_rs;
    logic [8*N-1:0]   req_rt;
    logic [7:0]       alu_rs;
    logic [7:0]       alu_rt;
    logic [1:0]       alu_op;
    logic [7:0]       alu_result;
    logic [N-1:0]     resp_valid;
    logic [7:0]       resp_data;
    logic             busy;
    logic [15:0]      op_count;

    // Stand-in ALU core: 8-bit wrap-around arithmetic, divide by zero gives 0xFF.
    always_comb begin
        case (alu_op)
            2'b00:   alu_result = alu_rs + alu_rt;
            2'b01:   alu_result = alu_rs - alu_rt;
            2'b10:   alu_result = 8'(alu_rs * alu_rt);
            default: alu_result = (alu_rt == 8'd0) ? 8'hFF : alu_rs / alu_rt;
        endcase
    end

    alu_share_arbiter #(.NUM_REQ(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_cmp    (req_cmp),
        .req_rs     (req_rs),
        .req_rt     (req_rt),
        .alu_rs     (alu_rs),
        .alu_rt     (alu_rt),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .busy       (busy),
        .op_count   (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    int compared   = 0;
    int mismatched = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] onehot(input int i);
        return N'(1) << i;
    endfunction

    // Reference result computed from the operation definitions.
    function automatic logic [7:0] ref_result(input logic [1:0] op, input logic cmp,
                                              input int rs, input int rt);
        int r;
        if (cmp) return (rs > rt) ? 8'd4 : (rs == rt) ? 8'd2 : 8'd1;
        case (op)
            2'b00:   r = (rs + rt) % 256;
            2'b01:   r = (rs - rt + 256) % 256;
            2'b10:   r = (rs * rt) % 256;
            default: r = (rt == 0) ? 255 : rs / rt;
        endcase
        return 8'(r);
    endfunction

    // Model state shared by all phases.
    int          m_ptr;
    logic [15:0] exp_count;

    task automatic count_op();
        if (exp_count != 16'hFFFF) exp_count = exp_count + 16'd1;
    endtask

    task automatic set_fields(input int id, input logic [1:0] op, input logic cmp,
                              input logic [7:0] rs, input logic [7:0] rt);
        req_op[2*id +: 2] = op;
        req_cmp[id]       = cmp;
        req_rs[8*id +: 8] = rs;
        req_rt[8*id +: 8] = rt;
    endtask

    // Single-requester transaction, entered at a falling edge with the DUT idle.
    task automatic do_txn(input int id, input logic [1:0] op, input logic cmp,
                          input logic [7:0] rs, input logic [7:0] rt, input logic [7:0] exp);
        enable    = 1'b1;
        set_fields(id, op, cmp, rs, rt);
        req_valid = onehot(id);
        #2 check("txn_ready", 32'(req_ready), 32'(onehot(id)));
        @(negedge clk);
        check("txn_busy", 32'(busy), 32'd1);
        check("txn_alu_op", 32'(alu_op), 32'(op));
        check("txn_alu_rs", 32'(alu_rs), 32'(rs));
        check("txn_alu_rt", 32'(alu_rt), 32'(rt));
        #2 check("txn_exec_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        req_valid = '0;
        count_op();
        m_ptr = id;
        check("txn_resp_valid", 32'(resp_valid), 32'(onehot(id)));
        check("txn_resp_data", 32'(resp_data), 32'(exp));
        check("txn_op_count", 32'(op_count), 32'(exp_count));
    endtask

    typedef struct {
        int         id;
        logic [1:0] op;
        logic       cmp;
        logic [7:0] rs;
        logic [7:0] rt;
        logic [7:0] exp;
    } vec_t;

    typedef struct {
        int         t;
        int         id;
        logic [7:0] d;
    } exp_t;

    vec_t        vecs[10];
    exp_t        sb[$];
    logic [N-1:0] pend;
    logic [1:0]  pop[N];
    logic        pcmp[N];
    logic [7:0]  prs[N];
    logic [7:0]  prt[N];
    int          cyc;
    int          lg_cyc;

    // One randomized cycle, entered at a falling edge.
    task automatic rand_cycle(input bit allow_new);
        bit free;
        int w;
        int idx;
        for (int i = 0; i < N; i++) begin
            if (!pend[i] && allow_new && ($urandom_range(1, 0) == 1)) begin
                pend[i] = 1'b1;
                pop[i]  = 2'($urandom_range(3, 0));
                pcmp[i] = ($urandom_range(3, 0) == 0);
                prs[i]  = 8'($urandom);
                prt[i]  = ($urandom_range(7, 0) == 0) ? 8'd0 : 8'($urandom);
            end
        end
        enable = allow_new ? ($urandom_range(7, 0) != 0) : 1'b0;
        for (int i = 0; i < N; i++) set_fields(i, pop[i], pcmp[i], prs[i], prt[i]);
        req_valid = pend;

        free = (lg_cyc != cyc - 1);
        w    = -1;
        if (free && enable && pend != '0) begin
            for (int k = 1; k <= N; k++) begin
                idx = (m_ptr + k) % N;
                if (w < 0 && pend[idx]) w = idx;
            end
        end
        #2;
        check("rnd_ready", 32'(req_ready), (w >= 0) ? 32'(onehot(w)) : 32'd0);
        check("rnd_busy", 32'(busy), free ? 32'd0 : 32'd1);
        if (w >= 0) begin
            sb.push_back('{t: cyc + 2, id: w,
                           d: ref_result(pop[w], pcmp[w], int'(prs[w]), int'(prt[w]))});
            m_ptr   = w;
            lg_cyc  = cyc;
            pend[w] = 1'b0;
        end
        @(negedge clk);
        cyc++;
        if (sb.size() > 0 && sb[0].t == cyc) begin
            check("rnd_resp_valid", 32'(resp_valid), 32'(onehot(sb[0].id)));
            check("rnd_resp_data", 32'(resp_data), 32'(sb[0].d));
            count_op();
            void'(sb.pop_front());
        end else begin
            check("rnd_resp_idle", 32'(resp_valid), 32'd0);
        end
        check("rnd_op_count", 32'(op_count), 32'(exp_count));
    endtask

    initial begin
        vecs[0] = '{id: 1, op: 2'b00, cmp: 1'b0, rs: 8'd5,   rt: 8'd3,  exp: 8'd8};
        vecs[1] = '{id: 2, op: 2'b00, cmp: 1'b1, rs: 8'd3,   rt: 8'd7,  exp: 8'b001};
        vecs[2] = '{id: 2, op: 2'b11, cmp: 1'b1, rs: 8'd9,   rt: 8'd9,  exp: 8'b010};
        vecs[3] = '{id: 2, op: 2'b01, cmp: 1'b1, rs: 8'd200, rt: 8'd7,  exp: 8'b100};
        vecs[4] = '{id: 0, op: 2'b01, cmp: 1'b0, rs: 8'd10,  rt: 8'd3,  exp: 8'd7};
        vecs[5] = '{id: 3, op: 2'b10, cmp: 1'b0, rs: 8'd20,  rt: 8'd13, exp: 8'd4};
        vecs[6] = '{id: 1, op: 2'b11, cmp: 1'b0, rs: 8'd100, rt: 8'd7,  exp: 8'd14};
        vecs[7] = '{id: 0, op: 2'b00, cmp: 1'b0, rs: 8'd250, rt: 8'd10, exp: 8'd4};
        vecs[8] = '{id: 2, op: 2'b01, cmp: 1'b0, rs: 8'd3,   rt: 8'd5,  exp: 8'd254};
        vecs[9] = '{id: 3, op: 2'b11, cmp: 1'b0, rs: 8'd9,   rt: 8'd0,  exp: 8'hFF};

        // Reset with every requester asking: no grant may leak out.
        reset     = 1'b1;
        enable    = 1'b1;
        req_valid = '1;
        req_op    = '0;
        req_cmp   = '0;
        req_rs    = '0;
        req_rt    = '0;
        @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        check("rst_ready2", 32'(req_ready), 32'd0);
        reset     = 1'b0;
        req_valid = '0;
        m_ptr     = N - 1;
        exp_count = '0;
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_data", 32'(resp_data), 32'd0);
        check("rst_op_count", 32'(op_count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_alu", {14'd0, alu_op, alu_rs, alu_rt}, 32'd0);

        // enable low: no grants while all four ask.
        enable    = 1'b0;
        req_valid = '1;
        for (int c = 0; c < 5; c++) begin
            #2;
            check("en_low_ready", 32'(req_ready), 32'd0);
            check("en_low_busy", 32'(busy), 32'd0);
            @(negedge clk);
        end

        // Continuous requests from everyone: strict 0,1,2,3,0,1 order, back to back.
        enable = 1'b1;
        for (int i = 0; i < N; i++) set_fields(i, 2'b00, 1'b0, 8'(i + 1), 8'd10);
        for (int k = 0; k < 6; k++) begin
            #2 check("rr_grant", 32'(req_ready), 32'(onehot(k % N)));
            @(negedge clk);
            check("rr_busy", 32'(busy), 32'd1);
            #2 check("rr_exec_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
            count_op();
            check("rr_resp_valid", 32'(resp_valid), 32'(onehot(k % N)));
            check("rr_resp_data", 32'(resp_data), 32'(11 + (k % N)));
            check("rr_op_count", 32'(op_count), 32'(exp_count));
        end
        req_valid = '0;
        m_ptr     = 1;
        @(negedge clk);
        check("rr_resp_drop", 32'(resp_valid), 32'd0);

        foreach (vecs[i])
            do_txn(vecs[i].id, vecs[i].op, vecs[i].cmp, vecs[i].rs, vecs[i].rt, vecs[i].exp);

        // Reset during EXEC discards the op.
        @(negedge clk);
        set_fields(3, 2'b01, 1'b0, 8'd50, 8'd8);
        req_valid = onehot(3);
        #2 check("rex_ready", 32'(req_ready), 32'(onehot(3)));
        @(negedge clk);
        check("rex_busy", 32'(busy), 32'd1);
        reset     = 1'b1;
        req_valid = '0;
        #2 check("rex_ready_in_reset", 32'(req_ready), 32'd0);
        @(negedge clk);
        reset     = 1'b0;
        exp_count = '0;
        m_ptr     = N - 1;
        check("rex_busy_after", 32'(busy), 32'd0);
        check("rex_resp_valid", 32'(resp_valid), 32'd0);
        check("rex_op_count", 32'(op_count), 32'd0);
        @(negedge clk);
        check("rex_no_late_resp", 32'(resp_valid), 32'd0);
        do_txn(3, 2'b01, 1'b0, 8'd50, 8'd8, 8'd42);

        // Reset while the response strobe is high kills it next cycle.
        reset = 1'b1;
        @(negedge clk);
        reset     = 1'b0;
        exp_count = '0;
        m_ptr     = N - 1;
        check("rsp_rst_valid", 32'(resp_valid), 32'd0);
        check("rsp_rst_count", 32'(op_count), 32'd0);

        // Randomized traffic against the reference model.
        pend   = '0;
        cyc    = 0;
        lg_cyc = -10;
        for (int i = 0; i < N; i++) begin
            pop[i] = 2'b00; pcmp[i] = 1'b0; prs[i] = 8'd0; prt[i] = 8'd0;
        end
        for (int c = 0; c < 400; c++) rand_cycle(1'b1);
        for (int c = 0; c < 4; c++) rand_cycle(1'b0);
        check("rnd_drained", 32'(sb.size()), 32'd0);
        pend      = '0;
        req_valid = '0;
        enable    = 1'b1;
        @(negedge clk);

        // Saturation: preload near the top, then complete more ops.
        force dut.op_count_q = 16'hFFFD;
        @(posedge clk);
        #1 release dut.op_count_q;
        @(negedge clk);
        exp_count = 16'hFFFD;
        check("sat_preload", 32'(op_count), 32'hFFFD);
        do_txn(0, 2'b00, 1'b0, 8'd1, 8'd1, 8'd2);
        do_txn(1, 2'b01, 1'b0, 8'd9, 8'd4, 8'd5);
        do_txn(2, 2'b10, 1'b0, 8'd3, 8'd3, 8'd9);
        check("sat_hold", 32'(op_count), 32'hFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Time-multiplexes one shared 8-bit ALU core among NUM_REQ requesters (threads) with round-robin arbitration and a valid/ready request handshake. It drives the core's operand and opcode inputs from registered state, samples the core's combinational result, and returns it to the winning requester tagged with a one-hot response strobe. It sits between the per-thread decode/register stage and a single ALU core instance, so several threads can share one ALU.

## Interface
- NUM_REQ, 4, number of requesters (2..8); IDW = $clog2(NUM_REQ)
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- enable  in  1  when low, no new grants; an in-flight op still completes
- req_valid  in  NUM_REQ  per-requester request
- req_ready  out  NUM_REQ  one-hot grant; combinational; transfer when valid&ready
- req_op  in  2*NUM_REQ  opcode per requester, slice i = [2i+1:2i]; 00 ADD, 01 SUB, 10 MUL, 11 DIV
- req_cmp  in  NUM_REQ  1 = compare op (NZP result), overrides req_op
- req_rs, req_rt  in  8*NUM_REQ  operands, slice i = [8i+7:8i]
- alu_rs, alu_rt  out  8  registered operands to ALU core
- alu_op  out  2  registered opcode to ALU core
- alu_result  in  8  combinational ALU core result
- resp_valid  out  NUM_REQ  one-hot, one-cycle result strobe
- resp_data  out  8  result, valid while any resp_valid bit is high
- busy  out  1  high in EXEC
- op_count  out  16  completed ops, saturates at 16'hFFFF

## Operation
- FSM states: IDLE, EXEC.
- IDLE: if enable and req_valid != 0, winner w = first set req_valid bit scanning from (last_grant+1) mod NUM_REQ upward, with wrap. req_ready[w]=1 combinationally; all other bits 0. On the clock edge:
  - alu_rs <= rs[w], alu_rt <= rt[w], alu_op <= op[w]
  - cmp_q <= cmp[w], grant_q <= w, last_grant <= w
  - state <= EXEC
- IDLE with no grant: state stays IDLE. alu_* registers hold their values.
- EXEC: req_ready = 0. busy = 1. On the edge:
  - resp_data <= cmp_q ? {5'b0, rs>rt, rs==rt, rs<rt} : alu_result. The compare is unsigned, on alu_rs/alu_rt.
  - resp_valid <= onehot(grant_q)
  - op_count increments, saturating
  - state <= IDLE
- resp_valid is high for exactly one cycle. This is the IDLE cycle after EXEC, and a new arbitration may happen in that same cycle.
- resp_data holds its last value until the next EXEC capture.
- Requesters must not drop req_valid or change their request fields before the transfer. Requesters have no back-pressure on responses.
- Reset values:
  - state IDLE, last_grant = NUM_REQ-1 (requester 0 has first priority)
  - alu_rs/alu_rt/alu_op/cmp_q/grant_q = 0
  - resp_valid = 0, resp_data = 0, op_count = 0, busy = 0
  - req_ready = 0 during reset

## Timing
- Accept at cycle T (IDLE, valid&ready). Core inputs are stable during T+1 (EXEC). resp_valid/resp_data are valid at T+2. Fixed latency is 2.
- Peak throughput: one op per 2 cycles. Back-to-back grant at T+2 gives the next response at T+4.
- Fairness: a continuously asserted requester is granted within NUM_REQ grants.
- enable deasserted in IDLE: no grant that cycle. Deasserted in EXEC: the op completes normally.
- Reset asserted in EXEC: the op is discarded, there is no resp_valid, and op_count returns to 0.
- Reset asserted with resp_valid high: resp_valid is 0 the next cycle.
- The single-requester case (only one bit valid) ignores the pointer and grants that requester.
- Arithmetic width and overflow behaviour come from the ALU core. The block passes alu_result through unmodified.

## Test plan
- Req1 ADD rs=5 rt=3 at T, others idle -> req_ready=4'b0010 at T, alu_op=00 during T+1, resp_valid=4'b0010 and resp_data=8 at T+2, op_count=1.
- All four requesters valid continuously after reset -> grant order 0,1,2,3,0,1. Grants every 2 cycles; each resp_valid strobe matches its grant.
- Req2 cmp=1 rs=3 rt=7 -> resp_data=8'b00000001. rs=9 rt=9 -> 8'b00000010. rs=200 rt=7 -> 8'b00000100.
- enable=0 with req_valid=4'b1111 for 5 cycles -> req_ready=0 and busy=0 throughout. enable=1 -> requester 0 granted first.
- Grant req3 SUB, then assert reset during EXEC -> no resp_valid, state IDLE. After reset, a req3-only request is granted and its result returns at +2.
- Preload op_count near saturation: 65535 ops by forced run or cross-check in a long run -> op_count stays 16'hFFFF after further completions.
